// File: rtl/byte_strip_pkg.sv
// Shared definitions for the 4-lane byte striper and unstriper:
// K-symbol codes, lane count and the buffered group record.
package byte_strip_pkg;

    localparam int LANES = 4;

    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;
    localparam logic [7:0] FTS = 8'h3C;
    localparam logic [7:0] COM = 8'hBC;

    typedef struct packed {
        logic [LANES-1:0][7:0] data;
        logic [LANES-1:0]      dk;
        logic                  os;
    } group_t;

    typedef enum logic {
        IDLE,
        SEND
    } out_state_e;

    function automatic logic is_os_sym(input logic [7:0] b);
        return (b == COM) || (b == SKP) || (b == IDL) || (b == FTS);
    endfunction

    function automatic logic is_k_sym(input logic [7:0] b);
        return is_os_sym(b) || (b == STP) || (b == SDP) ||
               (b == END) || (b == EDB);
    endfunction

endpackage

// File: rtl/byte_unstrip_fifo.sv
// Synchronous FIFO of 4-lane group records; exposes the head and the
// entry behind it so the reader can chain groups without a bubble.
module unstrip_fifo
    import byte_strip_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  group_t                   wr_data_i,
    input  logic                     rd_en_i,
    output group_t                   head_o,
    output group_t                   next_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    group_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_nxt;
    logic [AW:0]     count_q;
    logic            do_wr;
    logic            do_rd;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;
    assign rd_nxt  = rd_ptr_q + AW'(1);
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_nxt];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_nxt;
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/byte_unstrip.sv
// Reassembles 4-lane symbol groups into one byte stream, collapsing
// ordered sets to a single byte and flagging lane-consistency errors.
module byte_unstrip
    import byte_strip_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] LANE0,
    input  logic [7:0] LANE1,
    input  logic [7:0] LANE2,
    input  logic [7:0] LANE3,
    input  logic       DK_0,
    input  logic       DK_1,
    input  logic       DK_2,
    input  logic       DK_3,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [7:0] D,
    output logic       DK,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       ERROR_DLL
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [LANES-1:0][7:0] lanes;
    logic [LANES-1:0]      ks;
    logic                  in_os;
    logic                  in_bad;
    group_t                in_g;
    group_t                head;
    group_t                nxt;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  wr;
    logic                  pop;

    out_state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] d_q, d_d;
    logic       dk_q, dk_d;
    logic       err_q, err_d;

    assign lanes = {LANE3, LANE2, LANE1, LANE0};
    assign ks    = {DK_3, DK_2, DK_1, DK_0};

    always_comb begin
        in_os = (&ks) && (lanes[1] == lanes[0]) &&
                (lanes[2] == lanes[0]) && (lanes[3] == lanes[0]) &&
                is_os_sym(lanes[0]);
        in_bad = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (ks[i] && ((is_os_sym(lanes[i]) && !in_os) ||
                          !is_k_sym(lanes[i])))
                in_bad = 1'b1;
        end
    end

    assign in_g     = '{data: lanes, dk: ks, os: in_os};
    assign IN_READY = !full;
    assign wr       = IN_VALID && !full;

    unstrip_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .wr_en_i   (wr),
        .wr_data_i (in_g),
        .rd_en_i   (pop),
        .head_o    (head),
        .next_o    (nxt),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count)
    );

    // A group arriving while the FIFO is (or is about to be) empty is
    // loaded straight from the lanes so it emits the following cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        d_d     = d_q;
        dk_d    = dk_q;
        pop     = 1'b0;
        err_d   = err_q | (wr & in_bad);
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SEND;
                    idx_d   = 2'd0;
                    d_d     = head.data[0];
                    dk_d    = head.dk[0];
                end else if (wr) begin
                    state_d = SEND;
                    idx_d   = 2'd0;
                    d_d     = in_g.data[0];
                    dk_d    = in_g.dk[0];
                end
            end
            SEND: begin
                if (OUT_READY) begin
                    if (head.os || idx_q == 2'd3) begin
                        pop   = 1'b1;
                        idx_d = 2'd0;
                        if (count > CW'(1)) begin
                            d_d  = nxt.data[0];
                            dk_d = nxt.dk[0];
                        end else if (wr) begin
                            d_d  = in_g.data[0];
                            dk_d = in_g.dk[0];
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                        d_d   = head.data[idx_d];
                        dk_d  = head.dk[idx_d];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            d_q     <= 8'h00;
            dk_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
            dk_q    <= dk_d;
            err_q   <= err_d;
        end
    end

    assign D         = d_q;
    assign DK        = dk_q;
    assign OUT_VALID = (state_q == SEND);
    assign ERROR_DLL = err_q;

endmodule

// File: tb/tb_byte_unstrip.sv
// Directed and random checks of byte_unstrip against an expected-byte
// queue built from the group classification rules.
module tb_byte_unstrip;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] ln [4];
    logic       kf [4];
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] D;
    logic       DK;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       ERROR_DLL;

    int errors = 0;
    int checks = 0;
    logic [8:0] q [$];
    logic err_exp = 1'b0;
    int n;

    always #5 CLK = ~CLK;

    byte_unstrip #(.FIFO_DEPTH(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .LANE0     (ln[0]),
        .LANE1     (ln[1]),
        .LANE2     (ln[2]),
        .LANE3     (ln[3]),
        .DK_0      (kf[0]),
        .DK_1      (kf[1]),
        .DK_2      (kf[2]),
        .DK_3      (kf[3]),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .D         (D),
        .DK        (DK),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ERROR_DLL (ERROR_DLL)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_os();
        logic r;
        r = ln[0] inside {8'hBC, 8'h1C, 8'h7C, 8'h3C};
        for (int i = 0; i < 4; i++)
            if (!kf[i] || ln[i] != ln[0]) r = 1'b0;
        return r;
    endfunction

    function automatic logic m_bad();
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (kf[i] && !(ln[i] inside {8'hFB, 8'h5C, 8'hFD, 8'hFE,
                                         8'h1C, 8'h7C, 8'h3C, 8'hBC}))
                r = 1'b1;
            if (kf[i] && (ln[i] inside {8'hBC, 8'h1C, 8'h7C, 8'h3C}) &&
                !m_os())
                r = 1'b1;
        end
        return r;
    endfunction

    task automatic set_group(input logic [7:0] a, b, c, d,
                             input logic [3:0] k);
        ln[0] = a; ln[1] = b; ln[2] = c; ln[3] = d;
        for (int i = 0; i < 4; i++) kf[i] = k[i];
    endtask

    // One clock: remember what is on the bus, cross the edge, then
    // update the model and check the transfer and the error flag.
    task automatic step();
        logic acc, xf, stall, pv, pdk;
        logic [7:0] pd;
        acc   = IN_VALID && IN_READY && !RESET;
        xf    = OUT_VALID && OUT_READY && !RESET;
        stall = OUT_VALID && !OUT_READY && !RESET;
        pv = OUT_VALID; pd = D; pdk = DK;
        @(posedge CLK);
        #1;
        if (RESET) begin
            q.delete();
            err_exp = 1'b0;
        end else begin
            if (xf) begin
                chk("byte_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) chk("byte", {pdk, pd}, q.pop_front());
            end
            if (stall)
                chk("hold", {OUT_VALID, DK, D}, {pv, pdk, pd});
            if (acc) begin
                if (m_os()) q.push_back({1'b1, ln[0]});
                else for (int i = 0; i < 4; i++) q.push_back({kf[i], ln[i]});
                if (m_bad()) err_exp = 1'b1;
            end
        end
        chk("error_dll", ERROR_DLL, err_exp);
    endtask

    task automatic drain();
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 200 && (q.size() != 0 || OUT_VALID); i++)
            step();
        chk("drain_q", q.size(), 0);
        chk("drain_valid", OUT_VALID, 0);
    endtask

    task automatic rand_group();
        logic [7:0] b;
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) begin
            set_group(8'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), 4'h0);
        end else if (k < 8) begin
            case ($urandom_range(0, 3))
                0: b = 8'hBC;
                1: b = 8'h1C;
                2: b = 8'h7C;
                default: b = 8'h3C;
            endcase
            set_group(b, b, b, b, 4'hF);
        end else if (k == 8) begin
            set_group(8'hFB, 8'($urandom), 8'($urandom), 8'hFD, 4'b1001);
        end else begin
            set_group(8'($urandom), 8'($urandom), 8'h55, 8'($urandom),
                      4'b0100);
        end
    endtask

    initial begin
        RESET = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        set_group(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        step();
        RESET = 1'b0;
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_d", {DK, D}, 9'h000);
        chk("rst_err", ERROR_DLL, 0);

        set_group(8'h11, 8'h22, 8'h33, 8'h44, 4'h0);
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        chk("lat_valid", OUT_VALID, 1);
        chk("lat_d", {DK, D}, 9'h011);
        drain();

        set_group(8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'hF);
        IN_VALID = 1'b1;
        step();
        set_group(8'h01, 8'h02, 8'h03, 8'h04, 4'h0);
        step();
        IN_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("os_no_gap", OUT_VALID, 1);
            step();
        end
        drain();

        set_group(8'h1C, 8'h1C, 8'h7C, 8'h1C, 4'hF);
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        chk("err_mixed_os", ERROR_DLL, 1);
        drain();
        chk("err_sticky", ERROR_DLL, 1);

        RESET = 1'b1;
        step();
        RESET = 1'b0;
        set_group(8'h10, 8'h20, 8'h55, 8'h40, 4'b0100);
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        chk("err_bad_k", ERROR_DLL, 1);
        drain();

        OUT_READY = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            set_group(8'(8'h80 + 4 * i), 8'(8'h81 + 4 * i),
                      8'(8'h82 + 4 * i), 8'(8'h83 + 4 * i), 4'h0);
            IN_VALID = 1'b1;
            if (IN_READY) n++;
            step();
        end
        IN_VALID = 1'b0;
        chk("fill_accepts", n, 4);
        chk("fill_ready", IN_READY, 0);
        chk("fill_hold_d", {DK, D}, 9'h080);
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("ready_before_pop", IN_READY, 0);
        step();
        chk("ready_after_pop", IN_READY, 1);
        drain();

        set_group(8'h51, 8'h52, 8'h53, 8'h54, 4'h0);
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        step();
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("mid_rst_valid", OUT_VALID, 0);
        chk("mid_rst_err", ERROR_DLL, 0);
        chk("mid_rst_ready", IN_READY, 1);
        set_group(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'h0);
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        chk("fresh_a0", {OUT_VALID, DK, D}, 10'h2A0);
        drain();

        set_group(8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'h0);
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        step();
        step();
        step();
        set_group(8'hD0, 8'hD1, 8'hD2, 8'hD3, 4'h0);
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        chk("wr_pop_d", {OUT_VALID, DK, D}, 10'h2D0);
        chk("wr_pop_ready", IN_READY, 1);
        drain();

        for (int i = 0; i < 400; i++) begin
            rand_group();
            IN_VALID = ($urandom_range(0, 9) < 7);
            OUT_READY = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
